// File: rtl/ct_ciu_snb_cr_collect.sv
// Snoop-response collector: round-robin grants one PIU CR per cycle, merges crresp per
// snoop ID, and presents the lowest-index completed sid over a valid/ready handshake.
module ct_ciu_snb_cr_collect #(
   parameter int PIU_NUM = 4,
   parameter int SID_NUM = 32,
   parameter int CRR_W   = 10
) (
   input  logic                       forever_cpuclk,
   input  logic                       cpurst,
   input  logic                       ac_issue_vld,
   input  logic [4:0]                 ac_issue_sid,
   input  logic [PIU_NUM-1:0]         ac_issue_mask,
   output logic                       ac_issue_rej,
   input  logic [PIU_NUM-1:0]         piu_cr_req,
   input  logic [PIU_NUM*CRR_W-1:0]   piu_cr_bus,
   output logic [PIU_NUM-1:0]         piu_cr_grant,
   output logic                       cmplt_vld,
   output logic [4:0]                 cmplt_sid,
   output logic [4:0]                 cmplt_resp,
   input  logic                       cmplt_rdy,
   output logic                       cr_err,
   output logic                       cr_no_op
);

   localparam int PTR_W = (PIU_NUM > 1) ? $clog2(PIU_NUM) : 1;

   logic [SID_NUM-1:0] busy_reg;
   logic [PIU_NUM-1:0] pend_reg [SID_NUM];
   logic [4:0]         resp_reg [SID_NUM];
   logic [PTR_W-1:0]   rr_reg;
   logic               cr_err_reg;

   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W:0]     scan_idx;
   logic [CRR_W-1:0]   sel_bus;
   logic [4:0]         cr_sid;
   logic [4:0]         cr_resp;
   logic               cr_ok;
   logic [SID_NUM-1:0] done_vec;
   logic [SID_NUM-1:0] alloc_hit;
   logic [SID_NUM-1:0] pop_hit;
   logic [SID_NUM-1:0] cr_hit;
   logic               pop;

   // Scan from the rr pointer upward with wrap; the first requester wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int i = 0; i < PIU_NUM; i++) begin
         scan_idx = {1'b0, rr_reg} + (PTR_W+1)'(i);
         if (scan_idx >= (PTR_W+1)'(PIU_NUM))
            scan_idx = scan_idx - (PTR_W+1)'(PIU_NUM);
         if (!grant_any && piu_cr_req[scan_idx[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx[PTR_W-1:0];
         end
      end
   end

   assign piu_cr_grant = grant_any ? (PIU_NUM'(1) << grant_idx) : '0;
   assign sel_bus      = piu_cr_bus[grant_idx*CRR_W +: CRR_W];
   assign cr_sid       = sel_bus[9:5];
   assign cr_resp      = sel_bus[4:0];
   // The CR is judged against the table as it stands, so a same-cycle allocate does not save it.
   assign cr_ok        = grant_any && busy_reg[cr_sid] && pend_reg[cr_sid][grant_idx];

   always_comb begin
      cmplt_sid = '0;
      for (int i = SID_NUM - 1; i >= 0; i--) begin
         if (done_vec[i])
            cmplt_sid = 5'(i);
      end
   end

   assign cmplt_vld    = |done_vec;
   assign cmplt_resp   = cmplt_vld ? resp_reg[cmplt_sid] : '0;
   assign pop          = cmplt_vld && cmplt_rdy;
   assign ac_issue_rej = ac_issue_vld && busy_reg[ac_issue_sid];
   assign cr_err       = cr_err_reg;
   assign cr_no_op     = ~|busy_reg && ~|piu_cr_req;

   generate
      for (genvar gi = 0; gi < SID_NUM; gi++) begin : g_entry
         assign done_vec[gi]  = busy_reg[gi] && (pend_reg[gi] == '0);
         assign alloc_hit[gi] = ac_issue_vld && !busy_reg[gi] && (ac_issue_sid == 5'(gi));
         assign pop_hit[gi]   = pop && (cmplt_sid == 5'(gi));
         assign cr_hit[gi]    = cr_ok && (cr_sid == 5'(gi));
      end
   endgenerate

   // pop only hits a DONE entry and cr_hit needs a set pend bit, so they never collide.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         for (int i = 0; i < SID_NUM; i++) begin
            busy_reg[i] <= 1'b0;
            pend_reg[i] <= '0;
            resp_reg[i] <= '0;
         end
         rr_reg     <= '0;
         cr_err_reg <= 1'b0;
      end else begin
         for (int i = 0; i < SID_NUM; i++) begin
            if (alloc_hit[i]) begin
               busy_reg[i] <= 1'b1;
               pend_reg[i] <= ac_issue_mask;
               resp_reg[i] <= '0;
            end else if (pop_hit[i]) begin
               busy_reg[i] <= 1'b0;
               pend_reg[i] <= '0;
               resp_reg[i] <= '0;
            end else if (cr_hit[i]) begin
               pend_reg[i][grant_idx] <= 1'b0;
               resp_reg[i]            <= resp_reg[i] | cr_resp;
            end
         end
         if (grant_any) begin
            rr_reg <= (grant_idx == PTR_W'(PIU_NUM - 1)) ? '0 : grant_idx + PTR_W'(1);
            if (!cr_ok)
               cr_err_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ct_ciu_snb_cr_collect.sv
// Directed bench for ct_ciu_snb_cr_collect: a vector table for per-cycle behaviour plus
// hand sequences for completion hold/priority and mid-operation reset.
module tb_ct_ciu_snb_cr_collect;

   logic        clk;
   logic        rst;
   logic        issue_vld;
   logic [4:0]  issue_sid;
   logic [3:0]  issue_mask;
   logic        issue_rej;
   logic [3:0]  req;
   logic [39:0] bus;
   logic [3:0]  grant;
   logic        vld;
   logic [4:0]  sid;
   logic [4:0]  resp;
   logic        rdy;
   logic        err;
   logic        no_op;

   int n_cmp = 0;
   int n_bad = 0;

   ct_ciu_snb_cr_collect dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .ac_issue_vld   (issue_vld),
      .ac_issue_sid   (issue_sid),
      .ac_issue_mask  (issue_mask),
      .ac_issue_rej   (issue_rej),
      .piu_cr_req     (req),
      .piu_cr_bus     (bus),
      .piu_cr_grant   (grant),
      .cmplt_vld      (vld),
      .cmplt_sid      (sid),
      .cmplt_resp     (resp),
      .cmplt_rdy      (rdy),
      .cr_err         (err),
      .cr_no_op       (no_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [4:0]  isid;
      logic [3:0]  imask;
      logic [3:0]  req;
      logic [39:0] bus;
      logic        rdy;
      logic [3:0]  g;
      logic        rej;
      logic        vld;
      logic [4:0]  sid;
      logic [4:0]  resp;
      logic        err;
      logic        noop;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [9:0] cr(input logic [4:0] s, input logic [4:0] r);
      return {s, r};
   endfunction

   function automatic vec_t row(input logic r, input logic iv, input logic [4:0] isid,
                                input logic [3:0] imask, input logic [3:0] rq,
                                input logic [39:0] b, input logic rd, input logic [3:0] g,
                                input logic rej, input logic v, input logic [4:0] s,
                                input logic [4:0] rs, input logic e, input logic n);
      vec_t t;
      t.rst = r; t.iv = iv; t.isid = isid; t.imask = imask; t.req = rq; t.bus = b;
      t.rdy = rd; t.g = g; t.rej = rej; t.vld = v; t.sid = s; t.resp = rs;
      t.err = e; t.noop = n;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      rst = 1'b0; issue_vld = 1'b0; issue_sid = '0; issue_mask = '0;
      req = '0; bus = '0; rdy = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [39:0] Z = 40'h0;

   initial begin
      clr();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // rst iv isid imask req bus rdy | grant rej vld sid resp err noop
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,1));
      tbl.push_back(row(0,1, 3,4'b0101,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,1));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0001,{30'h0,cr(3,5'b00001)},0, 4'b0001,0,0, 0,5'b00000,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0100,{10'h0,cr(3,5'b01000),20'h0},0, 4'b0100,0,0, 0,5'b00000,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,1, 3,5'b01001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,1, 4'b0000,0,1, 3,5'b01001,0,0));
      tbl.push_back(row(1,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,1));
      tbl.push_back(row(0,1,10,4'b0001,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,1));
      tbl.push_back(row(0,1,11,4'b0010,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,0));
      tbl.push_back(row(0,1,12,4'b0100,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,0));
      tbl.push_back(row(0,1,13,4'b1000,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b1111,{cr(13,5'b01000),cr(12,5'b00100),cr(11,5'b00010),cr(10,5'b00001)},0, 4'b0001,0,0, 0,5'b00000,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b1110,{cr(13,5'b01000),cr(12,5'b00100),cr(11,5'b00010),cr(10,5'b00001)},0, 4'b0010,0,1,10,5'b00001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b1100,{cr(13,5'b01000),cr(12,5'b00100),cr(11,5'b00010),cr(10,5'b00001)},0, 4'b0100,0,1,10,5'b00001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b1000,{cr(13,5'b01000),cr(12,5'b00100),cr(11,5'b00010),cr(10,5'b00001)},0, 4'b1000,0,1,10,5'b00001,0,0));
      tbl.push_back(row(0,1,14,4'b1001,4'b0000,Z,0, 4'b0000,0,1,10,5'b00001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b1001,{cr(14,5'b00001),20'h0,cr(14,5'b10000)},0, 4'b0001,0,1,10,5'b00001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b1000,{cr(14,5'b00001),20'h0,cr(14,5'b10000)},0, 4'b1000,0,1,10,5'b00001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,1, 4'b0000,0,1,10,5'b00001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,1, 4'b0000,0,1,11,5'b00010,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,1, 4'b0000,0,1,12,5'b00100,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,1, 4'b0000,0,1,13,5'b01000,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,1, 4'b0000,0,1,14,5'b10001,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,1));
      tbl.push_back(row(0,1, 5,4'b0000,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,1));
      tbl.push_back(row(0,1, 5,4'b1111,4'b0000,Z,0, 4'b0000,1,1, 5,5'b00000,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,1, 5,5'b00000,0,0));
      tbl.push_back(row(0,1, 5,4'b0011,4'b0000,Z,1, 4'b0000,1,1, 5,5'b00000,0,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,0,1));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0001,{30'h0,cr(9,5'b00111)},0, 4'b0001,0,0, 0,5'b00000,0,0));
      tbl.push_back(row(0,1, 6,4'b0010,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,1,1));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0010,{20'h0,cr(6,5'b00011),10'h0},0, 4'b0010,0,0, 0,5'b00000,1,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0010,{20'h0,cr(6,5'b00100),10'h0},0, 4'b0010,0,1, 6,5'b00011,1,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,1, 6,5'b00011,1,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,1, 4'b0000,0,1, 6,5'b00011,1,0));
      tbl.push_back(row(0,0, 0,4'b0000,4'b0000,Z,0, 4'b0000,0,0, 0,5'b00000,1,1));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; issue_vld = tbl[i].iv; issue_sid = tbl[i].isid;
         issue_mask = tbl[i].imask; req = tbl[i].req; bus = tbl[i].bus; rdy = tbl[i].rdy;
         #2;
         $display("vec %0d: grant=%b rej=%b vld=%b sid=%0d resp=%b err=%b no_op=%b",
                  i, grant, issue_rej, vld, sid, resp, err, no_op);
         chk($sformatf("v%0d grant", i), 32'(grant),     32'(tbl[i].g));
         chk($sformatf("v%0d rej", i),   32'(issue_rej), 32'(tbl[i].rej));
         chk($sformatf("v%0d vld", i),   32'(vld),       32'(tbl[i].vld));
         chk($sformatf("v%0d sid", i),   32'(sid),       32'(tbl[i].sid));
         chk($sformatf("v%0d resp", i),  32'(resp),      32'(tbl[i].resp));
         chk($sformatf("v%0d err", i),   32'(err),       32'(tbl[i].err));
         chk($sformatf("v%0d no_op", i), 32'(no_op),     32'(tbl[i].noop));
         step();
      end
      clr();

      // Completion hold and lower-sid preemption: sid 7 done first, then sid 2.
      issue_vld = 1'b1; issue_sid = 5'd7; issue_mask = 4'b0001; step();
      issue_sid = 5'd2; issue_mask = 4'b0100; step();
      clr(); req = 4'b0001; bus = {30'h0, cr(7, 5'b00010)}; #2;
      chk("hold g7", 32'(grant), 32'(4'b0001));
      step();
      clr(); req = 4'b0100; bus = {10'h0, cr(2, 5'b00001), 20'h0}; #2;
      $display("hold pre: vld=%b sid=%0d resp=%b grant=%b", vld, sid, resp, grant);
      chk("hold sid7", 32'(sid), 32'd7);
      chk("hold resp7", 32'(resp), 32'(5'b00010));
      chk("hold g2", 32'(grant), 32'(4'b0100));
      step();
      clr();
      for (int c = 0; c < 3; c++) begin
         #2;
         $display("hold %0d: vld=%b sid=%0d resp=%b", c, vld, sid, resp);
         chk($sformatf("hold%0d vld", c), 32'(vld), 32'd1);
         chk($sformatf("hold%0d sid", c), 32'(sid), 32'd2);
         chk($sformatf("hold%0d resp", c), 32'(resp), 32'(5'b00001));
         step();
      end
      rdy = 1'b1; #2;
      chk("pop2 sid", 32'(sid), 32'd2);
      step();
      #2;
      $display("pop: vld=%b sid=%0d resp=%b", vld, sid, resp);
      chk("next sid7", 32'(sid), 32'd7);
      chk("next resp7", 32'(resp), 32'(5'b00010));
      chk("next vld", 32'(vld), 32'd1);
      step();
      rdy = 1'b0; #2;
      chk("drained vld", 32'(vld), 32'd0);

      // Reset with three entries waiting and requests pending.
      clr();
      issue_vld = 1'b1; issue_mask = 4'b1111;
      issue_sid = 5'd20; step();
      issue_sid = 5'd21; step();
      issue_sid = 5'd22; step();
      clr();
      rst = 1'b1; req = 4'b0111;
      bus = {10'h0, cr(22, 5'b00100), cr(21, 5'b00010), cr(20, 5'b00001)};
      #2;
      chk("prerst err", 32'(err), 32'd1);
      step();
      clr();
      issue_vld = 1'b1; issue_sid = 5'd20; issue_mask = 4'b0001; #2;
      $display("post rst: vld=%b err=%b no_op=%b rej=%b", vld, err, no_op, issue_rej);
      chk("rst vld", 32'(vld), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst no_op", 32'(no_op), 32'd1);
      chk("reissue20 rej", 32'(issue_rej), 32'd0);
      step();
      issue_sid = 5'd21; req = 4'b0001; bus = {30'h0, cr(20, 5'b00101)}; #2;
      chk("reissue21 rej", 32'(issue_rej), 32'd0);
      chk("rst rr grant", 32'(grant), 32'(4'b0001));
      step();
      clr(); #2;
      $display("after reissue: vld=%b sid=%0d resp=%b err=%b", vld, sid, resp, err);
      chk("re vld", 32'(vld), 32'd1);
      chk("re sid", 32'(sid), 32'd20);
      chk("re resp", 32'(resp), 32'(5'b00101));
      chk("re err", 32'(err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
